// File: rtl/wb_sample_fifo_if.sv
// Wishbone slave-side bus bundle for the sample FIFO register window.
// Signal names keep the SoC's _i/_o suffixes, seen from the slave.
interface wb_sample_fifo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sample_fifo.sv
// Sample FIFO filled by an acquisition peripheral and drained by firmware over
// a 4-register Wishbone window; level-threshold / overflow interrupt.
module wb_sample_fifo #(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  wb_sample_fifo_if.slave          wbs,
  input  logic                     smp_valid_i,
  input  logic [DATA_W-1:0]        smp_data_i,
  output logic                     irq_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              en, thr_ie, ovf_ie, ovf, unf, ack;
  logic [7:0]        thresh;

  logic        sel, access, wr, rd, empty, full;
  logic        pop_req, pop, unf_set, flush, push_req, push, ovf_set;
  logic        ovf_clr, unf_clr, ctrl_wr, irq_next;
  logic [1:0]  off;
  logic [8:0]  cnt9;
  logic [7:0]  cnt8;
  logic [31:0] rdata;
  logic        unused_bits;

  assign sel    = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access = sel & ~ack;
  assign off    = wbs.wbs_adr_i[3:2];
  assign wr     = access & wbs.wbs_we_i;
  assign rd     = access & ~wbs.wbs_we_i;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  assign pop_req  = rd & (off == 2'd0);
  assign pop      = pop_req & ~empty;
  assign unf_set  = pop_req & empty;
  assign flush    = wr & (off == 2'd2) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[3];
  // A pop on the same edge frees the slot, so a full FIFO still accepts it.
  assign push_req = smp_valid_i & en & ~flush;
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr & (off == 2'd1) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[2];
  assign unf_clr  = wr & (off == 2'd1) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[3];
  assign ctrl_wr  = wr & (off == 2'd2);

  // The 8-bit count field saturates so DEPTH=256 still reads as >= any THRESH.
  assign cnt9 = 9'(count);
  assign cnt8 = cnt9[8] ? 8'hFF : cnt9[7:0];

  assign irq_next = (thr_ie & (thresh != 8'd0) & (cnt8 >= thresh)) | (ovf_ie & ovf);

  always_comb begin
    rdata = '0;
    case (off)
      2'd0:    rdata = empty ? 32'd0 : 32'(mem[rd_ptr]);
      2'd1:    rdata = {16'h0, cnt8, 4'h0, unf, ovf, full, empty};
      2'd2:    rdata = {16'h0, thresh, 5'h0, ovf_ie, thr_ie, en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      en     <= 1'b0;
      thr_ie <= 1'b0;
      ovf_ie <= 1'b0;
      thresh <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      ack    <= 1'b0;
      irq_o  <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      ack           <= access;
      wbs.wbs_dat_o <= rd ? rdata : 32'd0;
      irq_o         <= irq_next;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push & ~pop)      count <= count + 1'b1;
        else if (pop & ~push) count <= count - 1'b1;
      end

      // A new event on the clearing edge wins so it is never lost.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (unf_clr) unf <= 1'b0;

      if (ctrl_wr && wbs.wbs_sel_i[0]) {ovf_ie, thr_ie, en} <= wbs.wbs_dat_i[2:0];
      if (ctrl_wr && wbs.wbs_sel_i[1]) thresh <= wbs.wbs_dat_i[15:8];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= smp_data_i;
  end

  assign wbs.wbs_ack_o = ack;
  assign fifo_level_o  = count;

  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16],
                         wbs.wbs_dat_i[7:4], wbs.wbs_sel_i[3:2]};

endmodule

// File: tb/tb_wb_sample_fifo.sv
// Bench for wb_sample_fifo: directed register-map scenarios, then random bus
// traffic and random pushes, all checked against a queue-based model.
module tb_wb_sample_fifo;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic smp_v = 1'b0;
  logic [DATA_W-1:0] smp_d = '0;
  logic irq;
  logic [$clog2(DEPTH):0] level;

  wb_sample_fifo_if wbs();

  wb_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(wbs),
    .smp_valid_i(smp_v), .smp_data_i(smp_d),
    .irq_o(irq), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit rnd_push = 1'b0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  bit        m_en, m_thr_ie, m_ovf_ie, m_ovf, m_unf, m_ack, m_irq;
  logic [7:0]  m_thresh;
  logic [31:0] m_dat;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 0; m_thr_ie = 0; m_ovf_ie = 0; m_ovf = 0; m_unf = 0;
    m_ack = 0; m_irq = 0; m_thresh = '0; m_dat = '0;
  endtask

  // One clock edge: sample the driven inputs, advance the model, compare.
  task automatic step();
    bit s, acc, wr, preq, flsh, pv, irq_nx;
    logic [1:0] off;
    logic [3:0] sl;
    logic [31:0] d, rexp;
    logic [DATA_W-1:0] pd;
    int cnt8, n;
    if (rnd_push) begin
      smp_v = ($urandom_range(0, 2) != 0);
      smp_d = DATA_W'($urandom);
    end
    pv  = smp_v; pd = smp_d;
    s   = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:4] == BASE[31:4]);
    acc = s && !m_ack;
    wr  = wbs.wbs_we_i;
    off = wbs.wbs_adr_i[3:2];
    sl  = wbs.wbs_sel_i;
    d   = wbs.wbs_dat_i;
    n   = q.size();
    cnt8 = (n > 255) ? 255 : n;
    irq_nx = (m_thr_ie && m_thresh != 0 && cnt8 >= int'(m_thresh)) || (m_ovf_ie && m_ovf);
    case (off)
      2'd0: rexp = (n > 0) ? 32'(q[0]) : 32'd0;
      2'd1: rexp = {16'h0, 8'(cnt8), 4'h0, m_unf, m_ovf, (n == DEPTH), (n == 0)};
      2'd2: rexp = {16'h0, m_thresh, 5'h0, m_ovf_ie, m_thr_ie, m_en};
      default: rexp = 32'd0;
    endcase
    preq = acc && !wr && off == 2'd0;
    flsh = acc && wr && off == 2'd2 && sl[0] && d[3];

    @(posedge clk);
    if (acc && wr && off == 2'd1 && sl[0]) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_unf = 0;
    end
    if (preq && n == 0) m_unf = 1;
    if (flsh) q.delete();
    else begin
      if (preq && n > 0) void'(q.pop_front());
      if (pv && m_en) begin
        if (q.size() < DEPTH) q.push_back(pd);
        else m_ovf = 1;
      end
    end
    if (acc && wr && off == 2'd2) begin
      if (sl[0]) {m_ovf_ie, m_thr_ie, m_en} = d[2:0];
      if (sl[1]) m_thresh = d[15:8];
    end
    m_ack = acc;
    m_dat = (acc && !wr) ? rexp : 32'd0;
    m_irq = irq_nx;

    #1;
    chk("ack", 32'(wbs.wbs_ack_o), 32'(m_ack));
    chk("dat_o", wbs.wbs_dat_o, m_dat);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("level", 32'(level), 32'(q.size()));
  endtask

  task automatic bus_idle();
    wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
    wbs.wbs_sel_i = '0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;
  endtask

  task automatic wb_op(input bit we_, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = we_;
    wbs.wbs_sel_i = s; wbs.wbs_adr_i = a; wbs.wbs_dat_i = d;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (!rnd_push) smp_v = 0;
      if (wbs.wbs_ack_o) begin got = 1; rd = wbs.wbs_dat_o; end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    bus_idle();
    step();
  endtask

  task automatic rd_reg(input logic [3:0] o, output logic [31:0] rd);
    wb_op(1'b0, BASE + 32'(o), 32'd0, 4'hF, rd);
  endtask

  task automatic wr_reg(input logic [3:0] o, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_op(1'b1, BASE + 32'(o), d, 4'hF, unused_rd);
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    smp_v = 1; smp_d = d;
    step();
    smp_v = 0;
  endtask

  initial begin
    logic [31:0] r;
    int kind;
    bus_idle();
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("rst_dat", wbs.wbs_dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    @(negedge clk); rst_n = 1;
    step();
    rd_reg(4'h4, r); chk("rst_status", r, 32'h0000_0001);
    rd_reg(4'h8, r); chk("rst_ctrl", r, 32'h0000_0000);

    // basic data path
    wr_reg(4'h8, 32'h1);
    push(16'h1111); push(16'h2222); push(16'h3333);
    rd_reg(4'h4, r); chk("basic_status", r, 32'h0000_0300);
    rd_reg(4'h0, r); chk("basic_d0", r, 32'h1111);
    rd_reg(4'h0, r); chk("basic_d1", r, 32'h2222);
    rd_reg(4'h0, r); chk("basic_d2", r, 32'h3333);
    rd_reg(4'h0, r); chk("basic_unf_rd", r, 32'h0);
    rd_reg(4'h4, r); chk("basic_unf_status", r, 32'h0000_0009);
    wr_reg(4'h4, 32'h8);
    rd_reg(4'hC, r); chk("reserved_rd", r, 32'h0);

    // overflow
    wr_reg(4'h8, 32'h5);
    for (int i = 0; i < 17; i++) push(16'(16'h0100 + i));
    step();
    chk("ovf_irq", 32'(irq), 32'd1);
    rd_reg(4'h4, r); chk("ovf_status", r, 32'h0000_1006);
    wr_reg(4'h4, 32'h4);
    chk("ovf_irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_reg(4'h0, r); chk("ovf_data", r, 32'h0100 + 32'(i));
    end
    rd_reg(4'h4, r); chk("ovf_drained", r, 32'h0000_0001);

    // simultaneous push/pop while full, then wrap readback
    wr_reg(4'h8, 32'h1);
    for (int i = 0; i < 16; i++) push(16'(16'h0200 + i));
    smp_v = 1; smp_d = 16'h02FF;
    rd_reg(4'h0, r); chk("sim_pop", r, 32'h0200);
    rd_reg(4'h4, r); chk("sim_status", r, 32'h0000_1002);
    for (int i = 1; i <= 16; i++) begin
      rd_reg(4'h0, r); chk("sim_wrap", r, (i < 16) ? 32'h0200 + 32'(i) : 32'h02FF);
    end

    // threshold irq
    wr_reg(4'h8, 32'h0000_0403);
    push(16'hA001); push(16'hA002); push(16'hA003);
    step();
    chk("thr_below", 32'(irq), 32'd0);
    push(16'hA004);
    step();
    chk("thr_hit", 32'(irq), 32'd1);
    rd_reg(4'h0, r); chk("thr_pop", r, 32'hA001);
    chk("thr_drop", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) rd_reg(4'h0, r);

    // flush with a same-cycle push
    wr_reg(4'h8, 32'h1);
    for (int i = 0; i < 5; i++) push(16'(16'h0300 + i));
    smp_v = 1; smp_d = 16'hAAAA;
    wb_op(1'b1, BASE + 32'h8, 32'h9, 4'h1, r);
    rd_reg(4'h4, r); chk("flush_status", r, 32'h0000_0001);
    rd_reg(4'h8, r); chk("flush_ctrl", r, 32'h0000_0001);

    // reset during an acked read
    wr_reg(4'h8, 32'h0000_0203);
    push(16'h0401); push(16'h0402);
    step(); step();
    chk("pre_rst_irq", 32'(irq), 32'd1);
    wbs.wbs_cyc_i = 1; wbs.wbs_stb_i = 1; wbs.wbs_we_i = 0;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = BASE;
    step();
    chk("pre_rst_ack", 32'(wbs.wbs_ack_o), 32'd1);
    rst_n = 0;
    #1;
    chk("async_ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    model_reset();
    bus_idle();
    @(negedge clk); rst_n = 1;
    step();
    rd_reg(4'h4, r); chk("post_rst_status", r, 32'h0000_0001);

    // random traffic
    rnd_push = 1;
    wr_reg(4'h8, 32'h0000_0807);
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: rd_reg(4'h0, r);
        3:       rd_reg(4'h4, r);
        4:       wb_op(1'b1, BASE + 32'h4, 32'($urandom_range(0, 15)), 4'($urandom), r);
        5:       wb_op(1'b1, BASE + 32'h8,
                       {16'h0, 8'($urandom_range(0, 20)), 4'h0,
                        ($urandom_range(0, 7) == 0), 2'($urandom), ($urandom_range(0, 4) != 0)},
                       4'($urandom), r);
        6:       rd_reg(4'h8, r);
        7:       wb_op($urandom_range(0, 1) == 1, BASE + 32'hC, $urandom, 4'hF, r);
        8: begin
          // outside the window (or stb without cyc): must never be acked
          wbs.wbs_cyc_i = ($urandom_range(0, 3) != 0); wbs.wbs_stb_i = 1;
          wbs.wbs_we_i = 0; wbs.wbs_sel_i = 4'hF;
          wbs.wbs_adr_i = wbs.wbs_cyc_i ? BASE + 32'h10 + 32'($urandom_range(0, 255)) : BASE;
          step(); step();
          bus_idle();
          step();
        end
        default: step();
      endcase
    end
    rnd_push = 0;
    smp_v = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
